// File: rtl/riscv_pkg.sv
// Shared widths, ALU opcodes and the ID/EX payload for the integer pipeline.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SRA = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  typedef struct packed {
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic [2:0]        alu_control;
    logic [REG_AW-1:0] rd_addr;
    logic              reg_write;
  } idex_entry_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// One-operand bypass select: MEM result beats WB result, x0 never bypassed.
// Bypassing is only built when IDEX_FWD_EN is defined; otherwise data passes through.
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [REG_AW-1:0] idx,
  input  logic [XLEN-1:0]   data_in,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   data_out_c
);

`ifdef IDEX_FWD_EN
  always_comb begin
    data_out_c = data_in;
    if (mem_we && (idx == mem_rd) && (idx != '0)) begin
      data_out_c = mem_data;
    end else if (wb_we && (idx == wb_rd) && (idx != '0)) begin
      data_out_c = wb_data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{idx, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data};
  assign data_out_c = data_in;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// Single-entry ID/EX pipeline register with valid/ready handshake, flush,
// and MEM/WB bypassing on capture and output (built only with IDEX_FWD_EN).
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic              use_imm,
  input  logic [2:0]        alu_control_in,
  input  logic [REG_AW-1:0] rd_addr_in,
  input  logic              reg_write_in,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  output logic [XLEN-1:0]   a,
  output logic [XLEN-1:0]   b,
  output logic [2:0]        alu_control,
  output logic [REG_AW-1:0] rd_addr,
  output logic              reg_write
);

  idex_entry_t     entry_q, entry_d;
  logic            out_valid_q, out_valid_d;
  logic            capture;
  logic [XLEN-1:0] cap_rs1, cap_rs2;
  logic [XLEN-1:0] out_rs1, out_rs2;

  assign in_ready = !out_valid_q || ex_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Incoming operands are bypassed before storage so the entry holds fresh data.
  fwd_mux u_cap_rs1 (
    .idx(rs1_addr), .data_in(rs1_data),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data_out_c(cap_rs1)
  );

  fwd_mux u_cap_rs2 (
    .idx(rs2_addr), .data_in(rs2_data),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data_out_c(cap_rs2)
  );

  fwd_mux u_out_rs1 (
    .idx(entry_q.rs1_addr), .data_in(entry_q.rs1_data),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data_out_c(out_rs1)
  );

  fwd_mux u_out_rs2 (
    .idx(entry_q.rs2_addr), .data_in(entry_q.rs2_data),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .data_out_c(out_rs2)
  );

  // Next entry: flush > capture > drain > stall (with WB snoop when bypassing).
  always_comb begin
    entry_d     = entry_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d         = 1'b1;
      entry_d.rs1_addr    = rs1_addr;
      entry_d.rs2_addr    = rs2_addr;
      entry_d.rs1_data    = cap_rs1;
      entry_d.rs2_data    = cap_rs2;
      entry_d.imm         = imm;
      entry_d.use_imm     = use_imm;
      entry_d.alu_control = alu_control_in;
      entry_d.rd_addr     = rd_addr_in;
      entry_d.reg_write   = reg_write_in;
    end else if (out_valid_q && ex_ready) begin
      out_valid_d = 1'b0;
`ifdef IDEX_FWD_EN
    end else if (out_valid_q) begin
      // A WB retiring while we stall would otherwise be lost next cycle.
      if (wb_we && (wb_rd == entry_q.rs1_addr) && (entry_q.rs1_addr != '0)) begin
        entry_d.rs1_data = wb_data;
      end
      if (wb_we && (wb_rd == entry_q.rs2_addr) && (entry_q.rs2_addr != '0)) begin
        entry_d.rs2_data = wb_data;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      entry_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      entry_q     <= entry_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign a           = out_rs1;
  assign b           = entry_q.use_imm ? entry_q.imm : out_rs2;
  assign alu_control = entry_q.alu_control;
  assign rd_addr     = entry_q.rd_addr;
  assign reg_write   = entry_q.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes expected entries, a monitor
// compares the presented outputs every cycle. Honours IDEX_FWD_EN like the RTL.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr_in, mem_rd, wb_rd, rd_addr;
  logic [31:0] rs1_data, rs2_data, imm, mem_data, wb_data, a, b;
  logic        use_imm, reg_write_in, flush, ex_ready, mem_we, wb_we;
  logic        out_valid, reg_write;
  logic [2:0]  alu_control_in, alu_control;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .use_imm(use_imm), .alu_control_in(alu_control_in),
    .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in), .flush(flush),
    .ex_ready(ex_ready), .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid),
    .a(a), .b(b), .alu_control(alu_control), .rd_addr(rd_addr), .reg_write(reg_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        use_imm, rw, flush, ex_ready;
    logic [2:0]  alu;
    logic        mem_we, wb_we;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_data, wb_data;
  } stim_t;

  typedef struct {
    logic [4:0]  rs1_idx, rs2_idx, rd;
    logic [31:0] rs1_val, rs2_val, imm;
    logic        use_imm, rw;
    logic [2:0]  alu;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register value an instruction should see given the current MEM/WB traffic.
  function automatic logic [31:0] ref_fwd(input logic [4:0] idx, input logic [31:0] val);
    if (idx == 5'd0) return val;
`ifdef IDEX_FWD_EN
    if (mem_we && mem_rd == idx) return mem_data;
    if (wb_we && wb_rd == idx) return wb_data;
`endif
    return val;
  endfunction

  function automatic stim_t idle(input logic er);
    stim_t s;
    s = '{default: '0};
    s.ex_ready = er;
    return s;
  endfunction

  function automatic stim_t instr(input logic [4:0] r1, input logic [31:0] d1,
                                  input logic [4:0] r2, input logic [31:0] d2,
                                  input logic [2:0] op, input logic er);
    stim_t s;
    s = idle(er);
    s.in_valid = 1'b1;
    s.rs1_addr = r1; s.rs1_data = d1;
    s.rs2_addr = r2; s.rs2_data = d2;
    s.alu = op; s.rd = 5'd7; s.rw = 1'b1; s.imm = 32'h0000_0FFF;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.in_valid = ($urandom_range(9) < 7);
    s.rs1_addr = 5'($urandom_range(3));
    s.rs2_addr = 5'($urandom_range(3));
    s.rd       = 5'($urandom_range(31));
    s.rs1_data = $urandom;
    s.rs2_data = $urandom;
    s.imm      = $urandom;
    s.use_imm  = 1'($urandom_range(1));
    s.rw       = 1'($urandom_range(1));
    s.alu      = 3'($urandom_range(7));
    s.flush    = ($urandom_range(19) == 0);
    s.ex_ready = ($urandom_range(9) < 6);
    s.mem_we   = 1'($urandom_range(1));
    s.mem_rd   = 5'($urandom_range(3));
    s.mem_data = $urandom;
    s.wb_we    = 1'($urandom_range(1));
    s.wb_rd    = 5'($urandom_range(3));
    s.wb_data  = $urandom;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    in_valid = s.in_valid; rs1_addr = s.rs1_addr; rs2_addr = s.rs2_addr;
    rs1_data = s.rs1_data; rs2_data = s.rs2_data; imm = s.imm; use_imm = s.use_imm;
    alu_control_in = s.alu; rd_addr_in = s.rd; reg_write_in = s.rw;
    flush = s.flush; ex_ready = s.ex_ready;
    mem_we = s.mem_we; mem_rd = s.mem_rd; mem_data = s.mem_data;
    wb_we = s.wb_we; wb_rd = s.wb_rd; wb_data = s.wb_data;
  endtask

  // Drive one cycle; after the monitor has run, record what the stage accepts.
  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    #3;
    if (s.flush) begin
      q.delete();
    end else if (s.in_valid && (q.size() == 0 || s.ex_ready)) begin
      e.rs1_idx = s.rs1_addr; e.rs1_val = ref_fwd(s.rs1_addr, s.rs1_data);
      e.rs2_idx = s.rs2_addr; e.rs2_val = ref_fwd(s.rs2_addr, s.rs2_data);
      e.imm = s.imm; e.use_imm = s.use_imm; e.alu = s.alu; e.rd = s.rd; e.rw = s.rw;
      q.push_back(e);
    end
  endtask

  // Monitor: compares the presented instruction and handshake each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'((q.size() == 0) || ex_ready));
        if (q.size() != 0) begin
          e = q[0];
          chk("a", a, ref_fwd(e.rs1_idx, e.rs1_val));
          chk("b", b, e.use_imm ? e.imm : ref_fwd(e.rs2_idx, e.rs2_val));
          chk("alu_control", 32'(alu_control), 32'(e.alu));
          chk("rd_addr", 32'(rd_addr), 32'(e.rd));
          chk("reg_write", 32'(reg_write), 32'(e.rw));
          if (ex_ready) begin
            void'(q.pop_front());
          end else if (!flush) begin
`ifdef IDEX_FWD_EN
            if (wb_we && wb_rd == e.rs1_idx && e.rs1_idx != 5'd0) e.rs1_val = wb_data;
            if (wb_we && wb_rd == e.rs2_idx && e.rs2_idx != 5'd0) e.rs2_val = wb_data;
`endif
            q[0] = e;
          end
        end
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    apply(idle(1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_alu", 32'(alu_control), 32'(ALU_ADD));
    mon_en = 1'b1;

    // back-to-back stream
    drive(instr(5'd1, 32'h5, 5'd2, 32'h7, ALU_ADD, 1'b1));
    drive(instr(5'd1, 32'h9, 5'd2, 32'h4, ALU_SUB, 1'b1));
    drive(instr(5'd1, 32'hF0, 5'd2, 32'h0F, ALU_XOR, 1'b1));
    drive(idle(1'b1));
    drive(idle(1'b1));

    // backpressure with a second instruction waiting
    drive(instr(5'd1, 32'h100, 5'd2, 32'h200, ALU_AND, 1'b0));
    repeat (3) drive(instr(5'd2, 32'h300, 5'd1, 32'h400, ALU_SLL, 1'b0));
    drive(instr(5'd2, 32'h300, 5'd1, 32'h400, ALU_SLL, 1'b1));
    drive(idle(1'b1));

    // forwarding priority on a held x3
    drive(instr(5'd3, 32'h11, 5'd4, 32'h55, ALU_ADD, 1'b0));
    s = idle(1'b0);
    s.mem_we = 1'b1; s.mem_rd = 5'd0; s.mem_data = 32'h22;
    s.wb_we = 1'b1; s.wb_rd = 5'd0; s.wb_data = 32'h33;
    drive(s);
    s.mem_rd = 5'd3; s.wb_rd = 5'd3;
    drive(s);
    s.mem_we = 1'b0;
    drive(s);
    drive(idle(1'b1));

    // WB snoop while stalled on rs2=x5
    drive(instr(5'd0, 32'h0, 5'd5, 32'h1, ALU_SRA, 1'b0));
    s = idle(1'b0);
    s.wb_we = 1'b1; s.wb_rd = 5'd5; s.wb_data = 32'hABCD;
    drive(s);
    drive(idle(1'b0));
    drive(idle(1'b0));
    drive(idle(1'b1));

    // flush kills held and incoming
    drive(instr(5'd1, 32'hAA, 5'd2, 32'hBB, ALU_SRL, 1'b0));
    s = instr(5'd2, 32'hCC, 5'd1, 32'hDD, ALU_SUB, 1'b0);
    s.flush = 1'b1;
    drive(s);
    drive(idle(1'b0));
    drive(idle(1'b1));

    // randomized traffic
    for (int i = 0; i < 400; i++) drive(rnd());
    drive(idle(1'b1));

    // asynchronous reset while an instruction is held
    drive(instr(5'd1, 32'h1234, 5'd2, 32'h5678, ALU_XOR, 1'b0));
    drive(idle(1'b0));
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    apply(idle(1'b0));
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_alu", 32'(alu_control), 32'(ALU_ADD));
    chk("midrst_a", a, 32'd0);
    chk("midrst_b", b, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    mon_en = 1'b1;
    drive(instr(5'd1, 32'h77, 5'd2, 32'h88, ALU_ADD, 1'b1));
    drive(idle(1'b1));
    drive(idle(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Single-entry pipeline register between decode and the ALU.
- Captures decoded operands, the 3-bit ALU opcode and destination info with a valid/ready handshake.
- Resolves RAW hazards by forwarding from the MEM and WB stages, and presents final a/b/alu_control to the ALU.
- Supports stall via downstream backpressure and flush for branch redirect.

Parameters:
XLEN, 32, datapath width (ALU operands)
REG_AW, 5, register address width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  decode has an instruction
in_ready  output  1  stage can accept this cycle
rs1_addr  input  REG_AW  source 1 index
rs2_addr  input  REG_AW  source 2 index
rs1_data  input  XLEN  regfile read data 1
rs2_data  input  XLEN  regfile read data 2
imm  input  XLEN  sign-extended immediate
use_imm  input  1  1: b takes imm instead of rs2
alu_control_in  input  3  ALU opcode from decoder
rd_addr_in  input  REG_AW  destination index
reg_write_in  input  1  instruction writes rd
flush  input  1  kill held and incoming instruction
ex_ready  input  1  ALU/EX consumes output this cycle
mem_we  input  1  MEM stage writes a register
mem_rd  input  REG_AW  MEM destination
mem_data  input  XLEN  MEM result
wb_we  input  1  WB stage writes a register
wb_rd  input  REG_AW  WB destination
wb_data  input  XLEN  WB result
out_valid  output  1  a/b/alu_control valid
a  output  XLEN  ALU src1 (signed)
b  output  XLEN  ALU src2 (signed)
alu_control  output  3  ALU opcode
rd_addr  output  REG_AW  destination to EX
reg_write  output  1  write enable to EX

Behaviour:
- Reset (async, immediate): out_valid=0; all stored fields and outputs 0; alu_control=3'b000 (ADD).
- in_ready = !out_valid || ex_ready. Combinational, no dependence on in_valid.
- Capture: in_valid && in_ready && !flush. Next edge stores all inputs and sets out_valid=1. Latency is 1 cycle.
- Drain: out_valid && ex_ready && no capture. Next edge sets out_valid=0.
- Simultaneous drain and capture: back-to-back throughput of 1 per cycle, no bubble.
- Stall (out_valid && !ex_ready): all stored fields are held, except the snoop rule below.
- Flush: next edge sets out_valid=0 and discards any same-cycle input. Flush dominates capture and stall.
- Forwarding at the output is combinational, per operand, using the stored source index and data:
  - If mem_we, index == mem_rd and index != 0, use mem_data.
  - Else if wb_we, index == wb_rd and index != 0, use wb_data.
  - Else use the stored data.
  - MEM beats WB. x0 is never forwarded.
- Forwarding on capture uses the same rules on the incoming rs1_data/rs2_data, so the stored value is already forwarded.
- WB snoop: while stalled, if wb_we matches a stored nonzero index, the stored data is overwritten with wb_data. A WB retiring during the stall is not lost.
- b output:
  - use_imm=1: b = stored imm; rs2 forwarding is ignored for b.
  - use_imm=0: b = forwarded rs2.
- alu_control passes through unmodified. Defined codes are 000 to 110; 111 is also passed through (ALU treats it as ADD).
- When out_valid=0, outputs hold their last values. Downstream must qualify with out_valid.

Optional Feature:
- Macro: IDEX_FWD_EN.
- Defined: forwarding and WB snoop exactly as above.
- Undefined: mem_*/wb_* ports remain present but are ignored. a = stored rs1_data, and b = stored rs2_data or imm. No snoop; the hazard unit must stall instead.

Decomposition:
- Package riscv_pkg holds:
  - XLEN, REG_AW.
  - ALU opcode constants: ALU_ADD=000, ALU_SUB=001, ALU_SRA=010, ALU_SLL=011, ALU_SRL=100, ALU_AND=101, ALU_XOR=110.
- One sub-module, fwd_mux: one operand's index/data plus the MEM/WB ports in, selected data out. Instanced twice for output and twice for capture.

Test Plan:
- Reset mid-stream with out_valid=1 -> out_valid=0, alu_control=000 and a=b=0 immediately, before the next edge.
- Stream 3 instructions with ex_ready=1 (ADD 5,7; SUB 9,4; XOR F0,0F) -> out_valid continuous for 3 cycles, each 1 cycle after capture, in_ready stays 1.
- Hold ex_ready=0 for 3 cycles with a second instruction offered -> in_ready=0, outputs stable, second instruction captured the cycle after ex_ready=1.
- Held rs1=x3 (stored 0x11), mem_we with mem_rd=3 and mem_data=0x22, plus wb_we with wb_rd=3 and wb_data=0x33 -> a=0x22. With MEM dropped -> a=0x33. With rd=0 on both -> a=0x11.
- Stall holding rs2=x5 with use_imm=0, wb writes x5=0xABCD for one cycle then deasserts -> b stays 0xABCD after release (snoop). With IDEX_FWD_EN undefined -> b reverts to the stored value.
- Flush asserted together with in_valid=1 and ex_ready=0 -> next cycle out_valid=0, the incoming instruction never appears, and in_ready=1.
